// File: rtl/pipe_stage_chain.sv
// Purpose : DEPTH-stage register chain with global stall and per-stage flush (bubble insert).
// Latency : DEPTH cycles from in_data/in_valid to out_data/out_valid when not stalled.
// Backpr. : no downstream backpressure; stall=1 holds every non-flushed stage, the last stage drops when stall=0.
//
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_data, in_valid    - entry presented to stage 0
//   stall                - hold all stages not being flushed this cycle
//   flush_mask[DEPTH]    - bit i turns stage i into a bubble at the next edge (wins over stall)
//   out_data, out_valid  - contents of stage DEPTH-1
//   stage_valid[DEPTH]   - valid bit of each stage
//   occupancy            - number of valid stages (0..DEPTH)
//   stall_cycles         - saturating count of stalled edges
//   flush_events         - saturating count of edges with any flush bit set
//
// Build option: define PIPE_STAGE_CHAIN_STATS_EN to implement the two statistics
// counters; without it both ports read constant zero and no counter flops exist.

module pipe_stage_chain #(
  parameter int                 WIDTH      = 32,
  parameter int                 DEPTH      = 2,
  parameter logic [WIDTH-1:0]   BUBBLE_VAL = '0,
  localparam int                OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic [DEPTH-1:0]      flush_mask,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [DEPTH-1:0]      stage_valid,
  output logic [OCC_W-1:0]      occupancy,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_events
);

  // ---------------------------------------------------------------------------
  // Stage storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Source feeding each stage on a non-stalled edge: the chain input for
  // stage 0, the pre-edge content of the previous stage otherwise.
  logic [WIDTH-1:0] src_data  [DEPTH];
  logic [DEPTH-1:0] src_valid;

  assign src_data[0]  = in_data;
  assign src_valid[0] = in_valid;

  for (genvar g = 1; g < DEPTH; g++) begin : g_src
    assign src_data[g]  = data_q[g-1];
    assign src_valid[g] = valid_q[g-1];
  end

  // Per-stage next state. A flush only affects the stage it targets: the
  // entry leaving that stage still moves on to the next stage, because the
  // next stage reads the registered (pre-edge) value.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    always_comb begin
      data_d[g]  = data_q[g];
      valid_d[g] = valid_q[g];
      if (flush_mask[g]) begin
        data_d[g]  = BUBBLE_VAL;
        valid_d[g] = 1'b0;
      end else if (!stall) begin
        data_d[g]  = src_data[g];
        valid_d[g] = src_valid[g];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= BUBBLE_VAL;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs derived from stage registers only
  // ---------------------------------------------------------------------------
  assign out_data    = data_q[DEPTH-1];
  assign out_valid   = valid_q[DEPTH-1];
  assign stage_valid = valid_q;

  // Population count; OCC_W bits always hold DEPTH so the sum cannot wrap.
  logic [OCC_W-1:0] occ_sum;

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + OCC_W'(valid_q[i]);
    end
  end

  assign occupancy = occ_sum;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef PIPE_STAGE_CHAIN_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic [15:0] flush_cnt_q;
  logic [15:0] flush_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if ((flush_mask != '0) && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);

`ifdef PIPE_STAGE_CHAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              stall = 1'b0;
  logic [DEPTH-1:0]  flush_mask = '0;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic [DEPTH-1:0]  stage_valid;
  logic [OCC_W-1:0]  occupancy;
  logic [15:0]       stall_cycles;
  logic [15:0]       flush_events;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_stage_chain #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .BUBBLE_VAL (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush_mask   (flush_mask),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .stage_valid  (stage_valid),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    tests_run++;
    if (stage_valid !== 3'b000) begin
      tests_failed++; $display("FAIL reset_stage_valid got=%b exp=000", stage_valid);
    end
    tests_run++;
    if (out_data !== 32'h0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out got=%h/%b exp=00000000/0", out_data, out_valid);
    end
    tests_run++;
    if (occupancy !== 2'd0 || stall_cycles !== 16'h0 || flush_events !== 16'h0) begin
      tests_failed++; $display("FAIL reset_counts got occ=%0d st=%h fl=%h exp=0/0000/0000",
                               occupancy, stall_cycles, flush_events);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    in_valid = 1'b1; in_data = 32'hA1; step();
    tests_run++;
    if (stage_valid !== 3'b001 || occupancy !== 2'd1) begin
      tests_failed++; $display("FAIL fill_edge1 got sv=%b occ=%0d exp=001/1", stage_valid, occupancy);
    end
    in_data = 32'hA2; step();
    in_data = 32'hA3; step();
    tests_run++;
    if (out_data !== 32'hA1 || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL fill_out got=%h/%b exp=000000a1/1", out_data, out_valid);
    end
    tests_run++;
    if (stage_valid !== 3'b111 || occupancy !== 2'd3) begin
      tests_failed++; $display("FAIL fill_occ got sv=%b occ=%0d exp=111/3", stage_valid, occupancy);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; in_data = 32'hFF; in_valid = 1'b1;
    step(4);
    tests_run++;
    if (out_data !== 32'hA1 || stage_valid !== 3'b111 || occupancy !== 2'd3) begin
      tests_failed++; $display("FAIL stall_hold got out=%h sv=%b occ=%0d exp=a1/111/3",
                               out_data, stage_valid, occupancy);
    end
    tests_run++;
    if (stall_cycles !== (STATS ? 16'd4 : 16'd0)) begin
      tests_failed++; $display("FAIL stall_count got=%0d exp=%0d", stall_cycles, STATS ? 4 : 0);
    end
  endtask

  // Chain holds A3/A2/A1 (stage0..2); flushing stage 1 under stall kills A2 only.
  task automatic test_flush_beats_stall();
    flush_mask = 3'b010; step();
    flush_mask = 3'b000;
    tests_run++;
    if (stage_valid !== 3'b101 || occupancy !== 2'd2 || out_data !== 32'hA1) begin
      tests_failed++; $display("FAIL flush_stall got sv=%b occ=%0d out=%h exp=101/2/a1",
                               stage_valid, occupancy, out_data);
    end
    tests_run++;
    if (flush_events !== (STATS ? 16'd1 : 16'd0)) begin
      tests_failed++; $display("FAIL flush_count1 got=%0d exp=%0d", flush_events, STATS ? 1 : 0);
    end
    stall = 1'b0; in_valid = 1'b0; in_data = 32'h55;
    step();
    tests_run++;
    if (out_data !== 32'h0 || out_valid !== 1'b0 || stage_valid !== 3'b010) begin
      tests_failed++; $display("FAIL flush_bubble_out got=%h/%b sv=%b exp=00000000/0/010",
                               out_data, out_valid, stage_valid);
    end
    step();
    tests_run++;
    if (out_data !== 32'hA3 || out_valid !== 1'b1 || occupancy !== 2'd1) begin
      tests_failed++; $display("FAIL flush_held_drain got=%h/%b occ=%0d exp=a3/1/1",
                               out_data, out_valid, occupancy);
    end
  endtask

  // Flushing stage 0 while shifting: B0 still moves into stage 1.
  task automatic test_flush_shift();
    in_valid = 1'b1; in_data = 32'hB0; step();
    in_data = 32'hC0; flush_mask = 3'b001; step();
    flush_mask = 3'b000; in_valid = 1'b0;
    tests_run++;
    if (stage_valid !== 3'b010 || occupancy !== 2'd1) begin
      tests_failed++; $display("FAIL flush_shift_sv got sv=%b occ=%0d exp=010/1", stage_valid, occupancy);
    end
    tests_run++;
    if (flush_events !== (STATS ? 16'd2 : 16'd0)) begin
      tests_failed++; $display("FAIL flush_count2 got=%0d exp=%0d", flush_events, STATS ? 2 : 0);
    end
    step();
    tests_run++;
    if (out_data !== 32'hB0 || out_valid !== 1'b1 || stage_valid !== 3'b100) begin
      tests_failed++; $display("FAIL flush_shift_out got=%h/%b sv=%b exp=b0/1/100",
                               out_data, out_valid, stage_valid);
    end
  endtask

  task automatic test_flush_all();
    in_valid = 1'b1;
    in_data = 32'hD1; step();
    in_data = 32'hD2; step();
    in_data = 32'hD3; step();
    flush_mask = 3'b111; in_data = 32'hD4; step();
    flush_mask = 3'b000; in_valid = 1'b0;
    tests_run++;
    if (stage_valid !== 3'b000 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      tests_failed++; $display("FAIL flush_all got sv=%b occ=%0d out=%h exp=000/0/0",
                               stage_valid, occupancy, out_data);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data = 32'hE1; step();
    in_data = 32'hE2; step();
    in_data = 32'hE3; step();
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (stage_valid !== 3'b000 || out_data !== 32'h0 || occupancy !== 2'd0 ||
        stall_cycles !== 16'h0 || flush_events !== 16'h0) begin
      tests_failed++; $display("FAIL async_reset got sv=%b out=%h occ=%0d st=%h fl=%h exp=all 0",
                               stage_valid, out_data, occupancy, stall_cycles, flush_events);
    end
    #1 rst = 1'b0;
    in_valid = 1'b1; in_data = 32'hF1; step();
    in_valid = 1'b0;
    tests_run++;
    if (stage_valid !== 3'b001 || occupancy !== 2'd1) begin
      tests_failed++; $display("FAIL post_reset got sv=%b occ=%0d exp=001/1", stage_valid, occupancy);
    end
  endtask

  task automatic test_stall_saturate();
    stall = 1'b1;
    step(65534);
    tests_run++;
    if (stall_cycles !== (STATS ? 16'hFFFE : 16'h0)) begin
      tests_failed++; $display("FAIL stall_pre_sat got=%h exp=%h", stall_cycles, STATS ? 16'hFFFE : 16'h0);
    end
    step(70000 - 65534);
    tests_run++;
    if (stall_cycles !== (STATS ? 16'hFFFF : 16'h0)) begin
      tests_failed++; $display("FAIL stall_sat got=%h exp=%h", stall_cycles, STATS ? 16'hFFFF : 16'h0);
    end
    tests_run++;
    if (stage_valid !== 3'b001) begin
      tests_failed++; $display("FAIL long_stall_hold got sv=%b exp=001", stage_valid);
    end
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_flush_beats_stall();
    test_flush_shift();
    test_flush_all();
    test_async_reset();
    test_stall_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data bits per stage (range 1..256).
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages in the chain (range 1..8).
REQ-003 SHALL have parameter BUBBLE_VAL, default 0 (WIDTH bits): data value loaded on reset and flush.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_data  input  WIDTH: payload entering stage 0.
REQ-007 SHALL have port in_valid  input  1: in_data carries a real entry.
REQ-008 SHALL have port stall  input  1: hold every non-flushed stage.
REQ-009 SHALL have port flush_mask  input  DEPTH: bit i turns stage i into a bubble at the next edge.
REQ-010 SHALL have port out_data  output  WIDTH: data of stage DEPTH-1.
REQ-011 SHALL have port out_valid  output  1: valid of stage DEPTH-1.
REQ-012 SHALL have port stage_valid  output  DEPTH: valid bit of every stage, bit i = stage i.
REQ-013 SHALL have port occupancy  output  clog2(DEPTH+1): number of valid stages.
REQ-014 SHALL have port stall_cycles  output  16: stall statistics counter (see Configuration).
REQ-015 SHALL have port flush_events  output  16: flush statistics counter (see Configuration).

Function
REQ-016 SHALL, per stage i, hold a WIDTH-bit data register and a 1-bit valid register; all outputs registered or derived combinationally from these registers only.
REQ-017 SHALL, when stall=0 and flush_mask[i]=0, load stage 0 from {in_valid,in_data} and stage i>0 from stage i-1 at the edge (1 cycle per stage; in->out latency DEPTH cycles).
REQ-018 SHALL, when stall=1 and flush_mask[i]=0, hold stage i unchanged; in_data/in_valid are ignored that cycle.
REQ-019 SHALL, when flush_mask[i]=1, load stage i with valid=0 and data=BUBBLE_VAL regardless of stall (flush beats stall, per stage).
REQ-020 SHALL, when stall=0 and flush_mask[i]=1 but flush_mask[i+1]=0, still shift the pre-edge content of stage i into stage i+1 (flush kills the incoming entry, not the departing one).
REQ-021 SHALL shift invalid entries like valid ones; data of an invalid stage is don't-care except after reset/flush where it equals BUBBLE_VAL.
REQ-022 SHALL drive occupancy as the population count of stage_valid, range 0..DEPTH, no overflow.
REQ-023 SHALL drop the entry in stage DEPTH-1 when stall=0 (no downstream backpressure; stall is the only hold).

Reset
REQ-024 SHALL, while rst=1, asynchronously force all stage valids to 0, all stage data to BUBBLE_VAL, occupancy to 0, stall_cycles and flush_events to 0.
REQ-025 SHALL, on rst asserted mid-stream, discard all in-flight entries; first edge after rst deasserts behaves per REQ-017..REQ-019.

Configuration
REQ-026 SHALL, with macro PIPE_STAGE_CHAIN_STATS_EN defined, increment stall_cycles on each edge with stall=1 and flush_events on each edge with flush_mask!=0, each saturating at 16'hFFFF.
REQ-027 SHALL, without PIPE_STAGE_CHAIN_STATS_EN, keep both ports present and tied to constant 0, with no counter registers synthesised.

Verification (WIDTH=32, DEPTH=3, BUBBLE_VAL=0)
REQ-028 SHALL cover: push 0xA1,0xA2,0xA3 valid on 3 edges, stall=0 -> out_data=0xA1,out_valid=1 at edge 3, occupancy=3.
REQ-029 SHALL cover: chain full, stall=1 for 4 edges with in_data=0xFF -> all stages unchanged, occupancy=3, stall_cycles=4 (STATS_EN).
REQ-030 SHALL cover: chain full, stall=1, flush_mask=3'b010 -> stage 1 valid=0 data=0, stages 0 and 2 held, occupancy=2.
REQ-031 SHALL cover: stall=0, flush_mask=3'b001, stage0=0xB0 -> next edge stage0 bubble, stage1=0xB0 valid.
REQ-032 SHALL cover: rst pulsed between edges with chain full -> outputs 0 immediately, no clock needed; 70000 stall cycles -> stall_cycles=0xFFFF.
